// File: rtl/tinker_pkg.sv
// Shared Tinker memory constants and the response-buffer state type.
package tinker_pkg;

    localparam int          MEM_BYTES = 524288;
    localparam logic [31:0] INIT_PC   = 32'h0000_2000;
    localparam logic [31:0] STACK_TOP = 32'h0008_0000;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    typedef enum logic {EMPTY, FULL} rsp_state_t;

endpackage

// File: rtl/tinker_mem_arbiter_if.sv
// Fetch, data and memory-side signals of the Tinker memory arbiter.
interface tinker_mem_arbiter_if #(parameter int ADDR_W = 32);

    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic              if_rsp_ready;
    logic [31:0]       if_rsp_instr;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [63:0]       d_wdata;
    logic              d_rsp_valid;
    logic              d_rsp_ready;
    logic [63:0]       d_rsp_data;
    logic              d_rsp_err;

    logic [ADDR_W-1:0] m_addr;
    logic              m_we;
    logic [63:0]       m_wdata;
    logic [63:0]       m_rdata;

    // slave is the arbiter; master is the pipeline plus the memory array
    modport slave (
        input  if_req_valid, if_addr, if_rsp_ready,
        output if_req_ready, if_rsp_valid, if_rsp_instr,
        input  d_req_valid, d_we, d_addr, d_wdata, d_rsp_ready,
        output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        output m_addr, m_we, m_wdata,
        input  m_rdata
    );

    modport master (
        output if_req_valid, if_addr, if_rsp_ready,
        input  if_req_ready, if_rsp_valid, if_rsp_instr,
        output d_req_valid, d_we, d_addr, d_wdata, d_rsp_ready,
        input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
        input  m_addr, m_we, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/tinker_rsp_buf.sv
// One-entry registered response buffer with valid/ready handshake.
//   state | meaning
//   EMPTY | no response held; a grant may be accepted
//   FULL  | response held stable until rsp_ready
module tinker_rsp_buf
    import tinker_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic         rsp_ready,
    input  logic [W-1:0] data_in,
    input  logic         err_in,
    output logic         free,
    output logic         rsp_valid,
    output logic [W-1:0] data,
    output logic         err
);

    rsp_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
            data  <= '0;
            err   <= 1'b0;
        end else if (clear) begin
            state <= EMPTY;
        end else if (load) begin
            state <= FULL;
            data  <= data_in;
            err   <= err_in;
        end else if (rsp_ready) begin
            state <= EMPTY;
        end
    end

    // a slot frees up in the same cycle the consumer takes the held response
    assign free      = (state == EMPTY) || rsp_ready;
    assign rsp_valid = (state == FULL);

endmodule

// File: rtl/tinker_mem_arbiter.sv
// Single-port arbiter sharing Tinker unified memory between fetch and data,
// data-priority with a fetch starvation guard.
module tinker_mem_arbiter
    import tinker_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int MEM_BYTES    = tinker_pkg::MEM_BYTES,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    tinker_mem_arbiter_if.slave  bus
);

    localparam int                SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_W-1:0] IF_MAX     = ADDR_W'(MEM_BYTES - 4);
    localparam logic [ADDR_W-1:0] D_MAX      = ADDR_W'(MEM_BYTES - 8);
    localparam logic [SW-1:0]     STREAK_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak;
    logic          if_free, d_free;
    logic          if_elig, d_elig;
    logic          if_grant, d_grant;
    logic          if_oor, d_oor;
    logic          if_err;
    logic [31:0]   if_data;
    logic [63:0]   d_load_data;

    assign if_elig  = bus.if_req_valid && if_free && !flush && !reset;
    assign d_elig   = bus.d_req_valid && d_free && !reset;
    assign if_grant = if_elig && (!d_elig || (streak == STREAK_MAX));
    assign d_grant  = d_elig && !if_grant;

    assign bus.if_req_ready = if_grant;
    assign bus.d_req_ready  = d_grant;

    assign if_oor = bus.if_addr > IF_MAX;
    assign d_oor  = bus.d_addr > D_MAX;

    always_comb begin
        bus.m_addr  = '0;
        bus.m_we    = 1'b0;
        bus.m_wdata = '0;
        if (d_grant) begin
            bus.m_addr  = bus.d_addr;
            bus.m_we    = bus.d_we && !d_oor;
            bus.m_wdata = bus.d_wdata;
        end else if (if_grant) begin
            bus.m_addr = bus.if_addr;
        end
    end

    assign d_load_data = (bus.d_we || d_oor) ? 64'h0 : bus.m_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            streak <= '0;
        end else if (d_grant && if_elig) begin
            if (streak != STREAK_MAX)
                streak <= streak + SW'(1);
        end else if (if_grant || !if_elig) begin
            streak <= '0;
        end
    end

    tinker_rsp_buf #(.W(32)) u_if_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .load      (if_grant),
        .rsp_ready (bus.if_rsp_ready),
        .data_in   (bus.m_rdata[31:0]),
        .err_in    (if_oor),
        .free      (if_free),
        .rsp_valid (bus.if_rsp_valid),
        .data      (if_data),
        .err       (if_err)
    );

    // out-of-range fetches are remembered as an error and presented as NOP
    assign bus.if_rsp_instr = if_err ? NOP : if_data;

    tinker_rsp_buf #(.W(64)) u_d_buf (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .load      (d_grant),
        .rsp_ready (bus.d_rsp_ready),
        .data_in   (d_load_data),
        .err_in    (d_oor),
        .free      (d_free),
        .rsp_valid (bus.d_rsp_valid),
        .data      (bus.d_rsp_data),
        .err       (bus.d_rsp_err)
    );

endmodule
